// File: rtl/wt_cache_seq_pkg.sv
// Shared definitions for the write-through cache tag-array sequencers.
// Every cache user derives its set count through num_sets() so all agree.
package wt_cache_seq_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_SINGLE = 2'd3
  } flush_state_e;

  // Valid bit value of a cleared tag entry; every sequencer write stores this.
  localparam logic TAG_VALID_CLEARED = 1'b0;

  // Sets = bytes / bytes-per-set; not necessarily a power of two.
  function automatic int num_sets(input int bytes, input int assoc, input int line);
    int set_bytes;
    set_bytes = assoc * line / 8;
    return (set_bytes == 0) ? 0 : bytes / set_bytes;
  endfunction

  // Index width, never below one bit.
  function automatic int idx_width(input int sets);
    return (sets <= 1) ? 1 : $clog2(sets);
  endfunction

endpackage

// File: rtl/wt_cache_flush_seq.sv
// Tag-array init/flush sequencer: clears valid bits of selected ways over all
// sets after reset and on request, and services single-set invalidations.
module wt_cache_flush_seq
  import wt_cache_seq_pkg::*;
#(
  parameter int CacheByteSize = 2261,
  parameter int SetAssoc      = 2,
  parameter int LineWidth     = 128,
  localparam int NumSets      = num_sets(CacheByteSize, SetAssoc, LineWidth),
  localparam int IdxW         = idx_width(NumSets)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  input  logic [SetAssoc-1:0] flush_way_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  input  logic                inv_valid_i,
  input  logic [IdxW-1:0]     inv_idx_i,
  output logic                inv_ready_o,
  output logic                inv_err_o,
  output logic                ram_req_o,
  input  logic                ram_gnt_i,
  output logic [IdxW-1:0]     ram_idx_o,
  output logic [SetAssoc-1:0] ram_way_o
);

  localparam logic [IdxW-1:0]     LastIdx = IdxW'(NumSets - 1);
  localparam logic [IdxW:0]       SetsExt = (IdxW + 1)'(NumSets);
  localparam logic [SetAssoc-1:0] AllWays = '1;

  if (NumSets == 0) begin : g_bad_geometry
    $error("wt_cache_flush_seq: cache geometry yields zero sets");
  end
  if (SetAssoc < 1 || SetAssoc > 8) begin : g_bad_assoc
    $error("wt_cache_flush_seq: SetAssoc must be 1..8");
  end

  flush_state_e        state;
  logic                pend;
  logic [SetAssoc-1:0] pend_mask;
  logic                nxt_pend;
  logic [SetAssoc-1:0] nxt_mask;
  logic                granted;
  logic                last_write;
  logic                inv_in_range;

  // Pending request as it would look after folding in this cycle's flush_req_i.
  assign nxt_pend     = pend | flush_req_i;
  assign nxt_mask     = pend_mask | (flush_req_i ? flush_way_i : '0);
  assign granted      = ram_req_o & ram_gnt_i;
  assign last_write   = granted && ((state == ST_SINGLE) || (ram_idx_o == LastIdx));
  assign inv_in_range = {1'b0, inv_idx_i} < SetsExt;
  // NOTE: a single continuous assign has no path that leaves it unassigned, so no latch.
  assign inv_ready_o  = (state == ST_IDLE) && !pend && !flush_req_i;

  // Main FSM, set counter (ram_idx_o) and registered outputs.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_INIT;
      pend        <= 1'b0;
      pend_mask   <= '0;
      ram_req_o   <= 1'b0;
      ram_idx_o   <= '0;
      ram_way_o   <= AllWays;
      flush_ack_o <= 1'b0;
      inv_err_o   <= 1'b0;
      busy_o      <= 1'b1;
    end else begin
      flush_ack_o <= 1'b0;
      inv_err_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (nxt_pend) begin
            // Flush wins over a same-cycle invalidate (inv_ready_o is low).
            pend      <= 1'b0;
            pend_mask <= '0;
            if (nxt_mask == '0) begin
              flush_ack_o <= 1'b1;
            end else begin
              state     <= ST_SWEEP;
              ram_req_o <= 1'b1;
              ram_idx_o <= '0;
              ram_way_o <= nxt_mask;
              busy_o    <= 1'b1;
            end
          end else if (inv_valid_i) begin
            if (inv_in_range) begin
              state     <= ST_SINGLE;
              ram_req_o <= 1'b1;
              ram_idx_o <= inv_idx_i;
              ram_way_o <= AllWays;
              busy_o    <= 1'b1;
            end else begin
              inv_err_o <= 1'b1;
            end
          end
        end
        default: begin
          // INIT, SWEEP and SINGLE: drive writes until the final grant.
          if (last_write) begin
            flush_ack_o <= (state == ST_SWEEP);
            if (nxt_pend && (nxt_mask != '0)) begin
              // Chain straight into the merged pending sweep, no bubble.
              state     <= ST_SWEEP;
              ram_idx_o <= '0;
              ram_way_o <= nxt_mask;
              pend      <= 1'b0;
              pend_mask <= '0;
            end else begin
              // A pending zero-mask flush is acknowledged from IDLE.
              state     <= ST_IDLE;
              ram_req_o <= 1'b0;
              busy_o    <= 1'b0;
              pend      <= nxt_pend;
              pend_mask <= nxt_mask;
            end
          end else begin
            pend      <= nxt_pend;
            pend_mask <= nxt_mask;
            // Only matters in the first INIT cycle after reset release.
            ram_req_o <= 1'b1;
            if (granted) begin
              ram_idx_o <= ram_idx_o + IdxW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wt_cache_flush_seq.sv
// Self-checking bench for wt_cache_flush_seq: default geometry (70 sets) plus
// a 43-set instance. Expected tag writes are queued when stimulus is driven
// and popped as the DUT completes writes.
module tb_wt_cache_flush_seq;

  typedef struct {
    int idx;
    int way;
  } wr_t;

  logic       clk;
  logic       rst_i;
  logic       flush_req_i;
  logic [1:0] flush_way_i;
  logic       flush_ack_o;
  logic       busy_o;
  logic       inv_valid_i;
  logic [6:0] inv_idx_i;
  logic       inv_ready_o;
  logic       inv_err_o;
  logic       ram_req_o;
  logic       ram_gnt_i;
  logic [6:0] ram_idx_o;
  logic [1:0] ram_way_o;

  logic       flush_req2;
  logic [1:0] flush_way2;
  logic       flush_ack2;
  logic       busy2;
  logic       inv_valid2;
  logic [5:0] inv_idx2;
  logic       inv_ready2;
  logic       inv_err2;
  logic       ram_req2;
  logic       ram_gnt2;
  logic [5:0] ram_idx2;
  logic [1:0] ram_way2;

  int  checks = 0;
  int  errors = 0;
  int  ack_cnt = 0;
  int  err_cnt = 0;
  int  req_cycles = 0;
  int  ack2_cnt = 0;
  bit  gnt_toggle = 0;
  wr_t exp_q[$];
  wr_t exp2_q[$];
  wr_t mon_e;
  wr_t mon2_e;
  bit         prev_stall = 0;
  logic [6:0] prev_idx;
  logic [1:0] prev_way;

  wt_cache_flush_seq dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_req_i(flush_req_i),
    .flush_way_i(flush_way_i),
    .flush_ack_o(flush_ack_o),
    .busy_o     (busy_o),
    .inv_valid_i(inv_valid_i),
    .inv_idx_i  (inv_idx_i),
    .inv_ready_o(inv_ready_o),
    .inv_err_o  (inv_err_o),
    .ram_req_o  (ram_req_o),
    .ram_gnt_i  (ram_gnt_i),
    .ram_idx_o  (ram_idx_o),
    .ram_way_o  (ram_way_o)
  );

  wt_cache_flush_seq #(.CacheByteSize(1378), .SetAssoc(2), .LineWidth(128)) dut_small (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_req_i(flush_req2),
    .flush_way_i(flush_way2),
    .flush_ack_o(flush_ack2),
    .busy_o     (busy2),
    .inv_valid_i(inv_valid2),
    .inv_idx_i  (inv_idx2),
    .inv_ready_o(inv_ready2),
    .inv_err_o  (inv_err2),
    .ram_req_o  (ram_req2),
    .ram_gnt_i  (ram_gnt2),
    .ram_idx_o  (ram_idx2),
    .ram_way_o  (ram_way2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; optionally toggle the grant.
  task automatic step();
    @(posedge clk);
    #1;
    if (gnt_toggle) ram_gnt_i = ~ram_gnt_i;
  endtask

  task automatic push_sweep(input int which, input int sets, input int way);
    for (int i = 0; i < sets; i++) begin
      if (which == 1) exp_q.push_back('{idx: i, way: way});
      else            exp2_q.push_back('{idx: i, way: way});
    end
  endtask

  task automatic do_flush(input logic [1:0] way);
    flush_req_i = 1'b1;
    flush_way_i = way;
    step();
    flush_req_i = 1'b0;
    flush_way_i = 2'b00;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy_o && n < budget) begin
      step();
      n++;
    end
    check(tag, busy_o, 0);
  endtask

  // Monitor for the 70-set instance: scoreboard, hold-while-stalled, counters.
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      prev_stall = 0;
    end else begin
      if (flush_ack_o) ack_cnt++;
      if (inv_err_o)   err_cnt++;
      if (ram_req_o)   req_cycles++;
      if (prev_stall) begin
        check("hold_req", ram_req_o, 1);
        check("hold_idx", ram_idx_o, prev_idx);
        check("hold_way", ram_way_o, prev_way);
      end
      if (ram_req_o) check("idx_range", ram_idx_o < 7'd70, 1);
      if (ram_req_o && ram_gnt_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_idx", ram_idx_o, mon_e.idx);
          check("wr_way", ram_way_o, mon_e.way);
        end
      end
      prev_stall = ram_req_o && !ram_gnt_i;
      prev_idx   = ram_idx_o;
      prev_way   = ram_way_o;
    end
  end

  // Monitor for the 43-set instance.
  initial forever begin
    @(negedge clk);
    if (!rst_i) begin
      if (flush_ack2) ack2_cnt++;
      if (ram_req2) check("geo_idx_range", ram_idx2 < 6'd43, 1);
      if (ram_req2 && ram_gnt2) begin
        if (exp2_q.size() == 0) begin
          check("geo_unexpected_write", exp2_q.size(), 1);
        end else begin
          mon2_e = exp2_q.pop_front();
          check("geo_wr_idx", ram_idx2, mon2_e.idx);
          check("geo_wr_way", ram_way2, mon2_e.way);
        end
      end
    end
  end

  initial begin
    int n;
    rst_i = 1'b1;
    flush_req_i = 1'b0; flush_way_i = 2'b00;
    inv_valid_i = 1'b0; inv_idx_i = 7'd0;
    ram_gnt_i = 1'b1;
    flush_req2 = 1'b0; flush_way2 = 2'b00;
    inv_valid2 = 1'b0; inv_idx2 = 6'd0; ram_gnt2 = 1'b1;
    repeat (2) step();

    // Reset values.
    check("rst_req", ram_req_o, 0);
    check("rst_busy", busy_o, 1);
    check("rst_way", ram_way_o, 2'b11);
    check("rst_idx", ram_idx_o, 0);
    check("rst_ack", flush_ack_o, 0);
    check("rst_err", inv_err_o, 0);
    check("rst_ready", inv_ready_o, 0);

    // Reset init: all 70 sets with both ways, then idle, no ack.
    push_sweep(1, 70, 3);
    push_sweep(2, 43, 3);
    rst_i = 1'b0;
    step();
    check("init_first_req", ram_req_o, 1);
    check("init_first_idx", ram_idx_o, 0);
    n = 1;
    while (busy_o && n < 200) begin
      step();
      n++;
    end
    check("init_cycles", n, 71);
    @(negedge clk);
    check("init_drained", exp_q.size(), 0);
    check("init_no_ack", ack_cnt, 0);
    check("geo_init_drained", exp2_q.size(), 0);
    check("geo_init_no_ack", ack2_cnt, 0);
    check("idle_ready", inv_ready_o, 1);

    // Back-pressure: grant low/high alternately, mask 01.
    ack_cnt = 0; req_cycles = 0;
    push_sweep(1, 70, 1);
    flush_req_i = 1'b1; flush_way_i = 2'b01;
    ram_gnt_i = 1'b1; gnt_toggle = 1;
    step();
    flush_req_i = 1'b0; flush_way_i = 2'b00;
    wait_idle(400, "bp_timeout");
    gnt_toggle = 0; ram_gnt_i = 1'b1;
    @(negedge clk);
    check("bp_ack", ack_cnt, 1);
    check("bp_req_cycles", req_cycles, 140);
    check("bp_drained", exp_q.size(), 0);

    // Pending merge: one request while busy becomes a second sweep.
    ack_cnt = 0;
    push_sweep(1, 70, 1);
    do_flush(2'b01);
    repeat (10) step();
    check("pm_ready_busy", inv_ready_o, 0);
    push_sweep(1, 70, 2);
    do_flush(2'b10);
    wait_idle(400, "pm_timeout");
    @(negedge clk);
    check("pm_ack", ack_cnt, 2);
    check("pm_drained", exp_q.size(), 0);

    // Two requests while busy OR-merge into one pending sweep of mask 11.
    ack_cnt = 0;
    push_sweep(1, 70, 1);
    do_flush(2'b01);
    repeat (5) step();
    do_flush(2'b01);
    repeat (10) step();
    do_flush(2'b10);
    push_sweep(1, 70, 3);
    wait_idle(400, "pm2_timeout");
    @(negedge clk);
    check("pm2_ack", ack_cnt, 2);
    check("pm2_drained", exp_q.size(), 0);

    // Single invalidate of set 5.
    ack_cnt = 0; err_cnt = 0;
    inv_valid_i = 1'b1; inv_idx_i = 7'd5;
    #1;
    check("inv_ready", inv_ready_o, 1);
    exp_q.push_back('{idx: 5, way: 3});
    step();
    inv_valid_i = 1'b0;
    check("single_busy", busy_o, 1);
    check("single_idx", ram_idx_o, 5);
    wait_idle(10, "single_timeout");
    @(negedge clk);
    check("single_drained", exp_q.size(), 0);

    // Out-of-range invalidate: error pulse, no RAM write.
    inv_valid_i = 1'b1; inv_idx_i = 7'd70;
    step();
    inv_valid_i = 1'b0;
    check("inv_err_pulse", inv_err_o, 1);
    check("inv_err_noreq", ram_req_o, 0);
    check("inv_err_busy", busy_o, 0);
    step();
    check("inv_err_clear", inv_err_o, 0);
    check("inv_err_count", err_cnt, 1);

    // Flush and invalidate together: flush wins.
    flush_req_i = 1'b1; flush_way_i = 2'b10;
    inv_valid_i = 1'b1; inv_idx_i = 7'd3;
    #1;
    check("both_ready", inv_ready_o, 0);
    push_sweep(1, 70, 2);
    step();
    flush_req_i = 1'b0; flush_way_i = 2'b00; inv_valid_i = 1'b0;
    wait_idle(200, "both_timeout");
    @(negedge clk);
    check("both_ack", ack_cnt, 1);
    check("both_drained", exp_q.size(), 0);

    // Zero mask: ack next cycle, no RAM traffic.
    ack_cnt = 0; req_cycles = 0;
    do_flush(2'b00);
    check("zm_ack", flush_ack_o, 1);
    check("zm_busy", busy_o, 0);
    step();
    check("zm_ack_clear", flush_ack_o, 0);
    check("zm_ack_count", ack_cnt, 1);
    check("zm_no_req", req_cycles, 0);

    // Reset mid-sweep with a flush pending.
    ack_cnt = 0;
    push_sweep(1, 70, 3);
    do_flush(2'b11);
    repeat (4) step();
    do_flush(2'b01);
    n = 0;
    while (ram_idx_o != 7'd30 && n < 100) begin
      step();
      n++;
    end
    check("mid_reach30", ram_idx_o, 30);
    rst_i = 1'b1;
    #1;
    check("mid_rst_req", ram_req_o, 0);
    check("mid_rst_busy", busy_o, 1);
    check("mid_rst_way", ram_way_o, 2'b11);
    check("mid_rst_idx", ram_idx_o, 0);
    check("mid_rst_ready", inv_ready_o, 0);
    exp_q.delete();
    exp2_q.delete();
    push_sweep(1, 70, 3);
    push_sweep(2, 43, 3);
    repeat (2) step();
    rst_i = 1'b0;
    step();
    check("mid_init_req", ram_req_o, 1);
    check("mid_init_idx", ram_idx_o, 0);
    wait_idle(200, "mid_timeout");
    repeat (5) step();
    check("mid_no_ack", ack_cnt, 0);
    check("mid_drained", exp_q.size(), 0);
    check("mid_still_idle", busy_o, 0);

    // 43-set geometry: sweep wraps after index 42.
    ack2_cnt = 0;
    push_sweep(2, 43, 2);
    flush_req2 = 1'b1; flush_way2 = 2'b10;
    step();
    flush_req2 = 1'b0; flush_way2 = 2'b00;
    n = 1;
    while (busy2 && n < 100) begin
      step();
      n++;
    end
    check("geo_cycles", n, 44);
    @(negedge clk);
    check("geo_ack", ack2_cnt, 1);
    check("geo_drained", exp2_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
